apb_req_arbiter: RTL
====================

Name: apb_req_arbiter

Overview:
Two-requester front end for the APB master bridge. Accepts read/write commands from two independent requesters, grants the single bridge round-robin, and drives transfer/READ_WRITE/address/data for one transaction at a time. Waits for access-phase completion or a timeout, then returns read data and error status to the granted requester. Sits between system-side masters and the APB_Protocol top-level inputs.

Parameters:
ADDR_W, 9, APB address width (bit 8 selects slave2)
DATA_W, 8, APB data width
TIMEOUT, 16, max WAIT cycles before forced abort (>=2)

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous active-high reset
m0_req_valid  in  1  requester 0 command valid
m0_req_ready  out  1  requester 0 command accepted (1-cycle pulse)
m0_req_write  in  1  1=write, 0=read
m0_req_addr  in  ADDR_W  command address
m0_req_wdata  in  DATA_W  write data
m0_rsp_valid  out  1  requester 0 response valid
m0_rsp_ready  in  1  requester 0 response taken
m0_rsp_rdata  out  DATA_W  read data (0 for writes/errors)
m0_rsp_err  out  1  PSLVERR or timeout
m1_*  (same eight ports for requester 1)
transfer  out  1  to bridge: transaction request
READ_WRITE  out  1  to bridge: 1=read, 0=write
apb_write_paddr  out  ADDR_W  to bridge
apb_write_data  out  DATA_W  to bridge
apb_read_paddr  out  ADDR_W  to bridge
xfer_done  in  1  pulse: access phase complete (PSEL&PENABLE&PREADY)
PSLVERR  in  1  from bridge, valid with xfer_done
apb_read_data_out  in  DATA_W  from bridge, valid with xfer_done
busy  out  1  state != IDLE
grant_id  out  1  requester currently owning the bridge

Behaviour:
- Reset (PRESET high at PCLK edge): state=IDLE; all outputs 0; last_grant=1 (requester 0 wins first); timeout counter=0. Applies mid-transaction: transfer drops next cycle, pending response discarded.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick winner: only one valid -> it; both -> the one != last_grant. Assert winner's req_ready for exactly this cycle, latch write/addr/wdata, set grant_id; next state ISSUE. No ready to the loser.
- ISSUE: transfer=1; READ_WRITE=~latched write; read: apb_read_paddr=addr, apb_write_paddr=0; write: apb_write_paddr=addr, apb_write_data=wdata, apb_read_paddr=0. Next WAIT, counter cleared.
- WAIT: transfer and bus fields held stable. On xfer_done: capture rdata=apb_read_data_out (reads) or 0 (writes), err=PSLVERR; next RESP. Else counter++; when counter reaches TIMEOUT-1 with no done: err=1, rdata=0, next RESP. done and expiry in same cycle -> done wins.
- RESP: transfer=0, bus fields 0; granted rsp_valid=1 with rdata/err held until rsp_ready sampled high; then last_grant=grant_id, next IDLE. Other requester's rsp_valid stays 0.
- xfer_done outside WAIT ignored. req_valid during non-IDLE states not acknowledged; requester must hold command.
- Latency: accept at T, transfer high T+1..done cycle D, rsp_valid from D+1; minimum accept-to-accept 4 cycles with rsp_ready held high.
- Only one requester's rsp_valid or req_ready high in any cycle.

Test Plan:
- Reset then m0 write addr 0x005 data 0xA5, xfer_done 3 cycles after transfer rises, PSLVERR=0 -> apb_write_paddr=0x005, apb_write_data=0xA5, READ_WRITE=0 during ISSUE/WAIT; m0_rsp_valid=1, err=0, rdata=0x00.
- m1 read addr 0x1F0, done with apb_read_data_out=0x3C -> READ_WRITE=1, apb_read_paddr=0x1F0; m1_rsp_rdata=0x3C, err=0.
- Both valid every cycle for 4 transactions -> grants m0,m1,m0,m1; never two req_ready in one cycle.
- No xfer_done with TIMEOUT=16 -> rsp_valid after exactly 16 WAIT cycles, err=1, rdata=0; transfer low in RESP.
- Done with PSLVERR=1 on read -> rsp_err=1, rdata=0x00 regardless of bus data; done coincident with timeout expiry -> err=PSLVERR, data captured.
- PRESET asserted during WAIT, then rsp_ready held low in RESP for 5 cycles on next transaction -> after reset all outputs 0, next grant to m0; rsp_valid/data stable for all 5 stall cycles.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin front end that lets two requesters share one
// APB master bridge, one transaction at a time, with a WAIT-phase timeout.
//
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   m0_* / m1_*             per-requester command (valid/ready) and
//                           response (valid/ready, rdata, err) channels
//   transfer, READ_WRITE    transaction request and direction to the bridge
//   apb_write_paddr/_data   write address/data to the bridge
//   apb_read_paddr          read address to the bridge
//   xfer_done, PSLVERR,     access-phase completion pulse, error and read
//   apb_read_data_out       data returned by the bridge
//   busy, grant_id          arbiter status
module apb_req_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_write,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    output logic              m0_rsp_err,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_write,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              m1_rsp_err,

    output logic              transfer,
    output logic              READ_WRITE,
    output logic [ADDR_W-1:0] apb_write_paddr,
    output logic [DATA_W-1:0] apb_write_data,
    output logic [ADDR_W-1:0] apb_read_paddr,
    input  logic              xfer_done,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] apb_read_data_out,

    output logic              busy,
    output logic              grant_id
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                gid_q, gid_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                pick;
    logic                rsp_taken;
    logic                on_bus;
    logic                in_resp;

    // Winner when both request: the one that was not served last.
    always_comb begin
        if (m0_req_valid && m1_req_valid) begin
            pick = ~last_q;
        end else begin
            pick = m1_req_valid;
        end
    end

    assign rsp_taken = gid_q ? m1_rsp_ready : m0_rsp_ready;

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        gid_d        = gid_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    m0_req_ready = ~pick;
                    m1_req_ready = pick;
                    gid_d        = pick;
                    write_d      = pick ? m1_req_write : m0_req_write;
                    addr_d       = pick ? m1_req_addr  : m0_req_addr;
                    wdata_d      = pick ? m1_req_wdata : m0_req_wdata;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion has priority over a simultaneous expiry.
                if (xfer_done) begin
                    err_d   = PSLVERR;
                    rdata_d = (!write_q && !PSLVERR) ?
                              apb_read_data_out : '0;
                    state_d = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_taken) begin
                    last_d  = gid_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus fields are driven only while the bridge is owned and are
    // otherwise forced to zero.
    assign on_bus  = (state_q == ISSUE) || (state_q == WAIT);
    assign in_resp = (state_q == RESP);

    assign transfer        = on_bus;
    assign READ_WRITE      = on_bus & ~write_q;
    assign apb_write_paddr = (on_bus && write_q)  ? addr_q  : '0;
    assign apb_write_data  = (on_bus && write_q)  ? wdata_q : '0;
    assign apb_read_paddr  = (on_bus && !write_q) ? addr_q  : '0;

    assign m0_rsp_valid = in_resp & ~gid_q;
    assign m1_rsp_valid = in_resp & gid_q;
    assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
    assign m0_rsp_err   = m0_rsp_valid & err_q;
    assign m1_rsp_err   = m1_rsp_valid & err_q;

    assign busy     = (state_q != IDLE);
    assign grant_id = gid_q;

endmodule
